dpwm_multicanal: RTL

DPWM_MULTICANAL -- requirements
Module: dpwm_multicanal

---
 rtl/dpwm_multicanal_pkg.sv | 19 +
 rtl/dpwm_multicanal_if.sv | 8 +
 rtl/dpwm_multicanal_sincronizador_boton.sv | 18 +
 rtl/dpwm_multicanal.sv | 124 ++++++++++++
 4 files changed

// File: rtl/dpwm_multicanal_pkg.sv
// Shared defaults, mode encoding and a width helper for the multichannel DPWM.
package dpwm_pkg;

  localparam int N_CANALES_DEF     = 4;
  localparam int ANCHO_DEF         = 8;
  localparam int PASO_DEF          = 16;
  localparam int TIEMPO_MUERTO_DEF = 4;

  typedef enum logic {
    MODO_BUCK   = 1'b0,
    MODO_PUENTE = 1'b1
  } modo_t;

  // A single channel still needs a 1-bit select port.
  function automatic int ancho_sel(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dpwm_multicanal_if.sv
// Raw button in, one-clock press pulse out; one instance per button.
interface dpwm_multicanal_if;
  logic boton;
  logic pulso;

  modport master (input boton, output pulso);
  modport slave  (output boton, input pulso);
endinterface

// File: rtl/dpwm_multicanal_sincronizador_boton.sv
// Two-flop synchronizer plus rising-edge detector for one raw button.
module sincronizador_boton (
  input logic              clk,
  input logic              rst_n,
  dpwm_multicanal_if.master pb
);

  // etapas[1:0] synchronize, etapas[2] remembers the previous synchronized level.
  logic [2:0] etapas;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) etapas <= '0;
    else        etapas <= {etapas[1:0], pb.boton};
  end

  assign pb.pulso = etapas[1] & ~etapas[2];

endmodule

// File: rtl/dpwm_multicanal.sv
// Multichannel DPWM: shared counter, per-channel shadow/active duty, buck or
// complementary full-bridge outputs with dead-time.
module dpwm_multicanal
  import dpwm_pkg::*;
#(
  parameter int N_CANALES     = N_CANALES_DEF,
  parameter int ANCHO         = ANCHO_DEF,
  parameter int PASO          = PASO_DEF,
  parameter int TIEMPO_MUERTO = TIEMPO_MUERTO_DEF
) (
  input  logic                              CLK_FPGA_BOARD,
  input  logic                              reinicio,
  input  logic                              boton_aumentar,
  input  logic                              boton_disminuir,
  input  logic [ancho_sel(N_CANALES)-1:0]   seleccion_canal,
  input  logic                              seleccion_modo,
  output logic [N_CANALES-1:0]              pwm_alto,
  output logic [N_CANALES-1:0]              pwm_bajo,
  output logic [ANCHO-1:0]                  ciclo_trabajo_sel,
  output logic                              inicio_periodo
);

  localparam int                W_SEL      = ancho_sel(N_CANALES);
  localparam int                W_TM       = $clog2(TIEMPO_MUERTO + 2);
  localparam logic [ANCHO-1:0]  CUENTA_MAX = '1;
  localparam logic [ANCHO-1:0]  PASO_N     = ANCHO'(PASO);
  localparam logic [ANCHO:0]    PASO_EXT   = {1'b0, PASO_N};
  localparam logic [W_TM-1:0]   TM         = W_TM'(TIEMPO_MUERTO);

  logic [ANCHO-1:0] contador;
  logic             fin_periodo;
  modo_t            modo_lat;

  assign fin_periodo = (contador == CUENTA_MAX);

  // inicio_periodo is registered from the last count so it stays low until
  // the first full period after reset has elapsed.
  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) begin
      contador       <= '0;
      inicio_periodo <= 1'b0;
      modo_lat       <= MODO_BUCK;
    end else begin
      contador       <= contador + 1'b1;
      inicio_periodo <= fin_periodo;
      if (fin_periodo) modo_lat <= modo_t'(seleccion_modo);
    end
  end

  dpwm_multicanal_if if_aum ();
  dpwm_multicanal_if if_dis ();

  assign if_aum.boton = boton_aumentar;
  assign if_dis.boton = boton_disminuir;

  sincronizador_boton u_sinc_aum (.clk(CLK_FPGA_BOARD), .rst_n(reinicio), .pb(if_aum));
  sincronizador_boton u_sinc_dis (.clk(CLK_FPGA_BOARD), .rst_n(reinicio), .pb(if_dis));

  // Coincident presses cancel out.
  logic sube, baja;
  assign sube = if_aum.pulso & ~if_dis.pulso;
  assign baja = if_dis.pulso & ~if_aum.pulso;

  logic [N_CANALES-1:0][ANCHO-1:0] sombra;

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    logic [ANCHO-1:0] sombra_q;
    logic [ANCHO-1:0] activo_q;
    logic [ANCHO:0]   suma;
    logic [W_TM-1:0]  racha_alto;
    logic [W_TM-1:0]  racha_bajo;
    logic             cmp;
    logic             elegido;
    logic             alto_q;
    logic             bajo_q;

    assign elegido = (seleccion_canal == W_SEL'(i));
    assign suma    = {1'b0, sombra_q} + PASO_EXT;
    assign cmp     = (contador < activo_q);

    // racha_* count how many previous consecutive cycles cmp held its level,
    // saturating at the dead-time; a gate opens once that run reaches it.
    always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
      if (!reinicio) begin
        sombra_q   <= '0;
        activo_q   <= '0;
        racha_alto <= '0;
        racha_bajo <= '0;
        alto_q     <= 1'b0;
        bajo_q     <= 1'b0;
      end else begin
        if (elegido && sube)
          sombra_q <= suma[ANCHO] ? '1 : suma[ANCHO-1:0];
        else if (elegido && baja)
          sombra_q <= (sombra_q < PASO_N) ? '0 : sombra_q - PASO_N;

        if (fin_periodo) activo_q <= sombra_q;

        racha_alto <= cmp  ? ((racha_alto == TM) ? TM : racha_alto + 1'b1) : '0;
        racha_bajo <= !cmp ? ((racha_bajo == TM) ? TM : racha_bajo + 1'b1) : '0;

        if (modo_lat == MODO_PUENTE) begin
          alto_q <= cmp  && (racha_alto == TM);
          bajo_q <= !cmp && (racha_bajo == TM);
        end else begin
          alto_q <= cmp;
          bajo_q <= 1'b0;
        end
      end
    end

    assign sombra[i]   = sombra_q;
    assign pwm_alto[i] = alto_q;
    assign pwm_bajo[i] = bajo_q;
  end

  always_comb begin
    ciclo_trabajo_sel = '0;
    for (int i = 0; i < N_CANALES; i++) begin
      if (seleccion_canal == W_SEL'(i)) ciclo_trabajo_sel = sombra[i];
    end
  end

endmodule
